// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: turns a PC into a single-beat ROM read, holds the result
// for the pipeline and abandons fetches after TIMEOUT_CYCLES. Optional macro: FETCH_ALIGN_CHECK_EN.
module inst_fetch_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        chip_enable,
   input  logic [31:0] program_counter,
   input  logic        flush_input,
   output logic [31:0] instruction,
   output logic        instruction_valid,
   output logic        stop_request,
   output logic        fetch_error,
   output logic        rom_request,
   output logic [31:0] rom_address,
   input  logic        rom_ready,
   input  logic [31:0] rom_data
);

   localparam int unsigned AW = 32;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   held_instr_q, held_instr_d;
   logic [AW-1:0]   held_addr_q, held_addr_d;
   logic [AW-1:0]   pend_addr_q, pend_addr_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            err_q, err_d;

   logic [AW-1:0]   pc_word;
   logic            hit;
   logic            accept;
   logic            misaligned;

   assign pc_word = program_counter & ~AW'(3);
   assign hit     = (state_q == ST_VALID) && (held_addr_q == pc_word);

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = |program_counter[1:0];
`else
   assign misaligned = 1'b0;
`endif

   // State and held-entry registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         held_instr_q <= '0;
         held_addr_q  <= '0;
         pend_addr_q  <= '0;
         wait_cnt_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         held_instr_q <= held_instr_d;
         held_addr_q  <= held_addr_d;
         pend_addr_q  <= pend_addr_d;
         wait_cnt_q   <= wait_cnt_d;
         err_q        <= err_d;
      end
   end

   // Next-state and held-entry update; flush and disable override everything
   always_comb begin
      state_d      = state_q;
      held_instr_d = held_instr_q;
      held_addr_d  = held_addr_q;
      pend_addr_d  = pend_addr_q;
      wait_cnt_d   = wait_cnt_q;
      err_d        = err_q;
      accept       = 1'b0;

      if (!chip_enable || flush_input) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  accept = 1'b1;
            ST_WAIT: begin
               if (rom_ready) begin
                  held_instr_d = rom_data;
                  held_addr_d  = pend_addr_q;
                  err_d        = 1'b0;
                  state_d      = ST_VALID;
               end else if (wait_cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
                  held_instr_d = '0;
                  held_addr_d  = pend_addr_q;
                  err_d        = 1'b1;
                  wait_cnt_d   = CW'(TIMEOUT_CYCLES);
                  state_d      = ST_VALID;
               end else begin
                  wait_cnt_d = wait_cnt_q + CW'(1);
               end
            end
            ST_VALID: accept = !hit;
            default:  state_d = ST_IDLE;
         endcase
      end

      if (accept) begin
         pend_addr_d = pc_word;
         wait_cnt_d  = '0;
         state_d     = ST_WAIT;
         // A rejected misaligned fetch resolves immediately as an error entry
         if (misaligned) begin
            held_instr_d = '0;
            held_addr_d  = pc_word;
            err_d        = 1'b1;
            state_d      = ST_VALID;
         end
      end
   end

   // Pipeline- and memory-side outputs; stall is suppressed while reset is asserted
   always_comb begin
      stop_request      = reset & chip_enable & ~hit;
      instruction_valid = chip_enable & hit;
      instruction       = instruction_valid ? held_instr_q : '0;
      fetch_error       = instruction_valid & err_q;
      rom_request       = (state_q == ST_WAIT);
      rom_address       = rom_request ? pend_addr_q : '0;
   end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder: a transaction-level model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_inst_fetch_responder;

   localparam int unsigned T = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        chip_enable = 1'b0;
   logic [31:0] program_counter = '0;
   logic        flush_input = 1'b0;
   logic [31:0] instruction;
   logic        instruction_valid;
   logic        stop_request;
   logic        fetch_error;
   logic        rom_request;
   logic [31:0] rom_address;
   logic        rom_ready = 1'b0;
   logic [31:0] rom_data = '0;

   inst_fetch_responder #(.TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset), .chip_enable(chip_enable),
      .program_counter(program_counter), .flush_input(flush_input),
      .instruction(instruction), .instruction_valid(instruction_valid),
      .stop_request(stop_request), .fetch_error(fetch_error),
      .rom_request(rom_request), .rom_address(rom_address),
      .rom_ready(rom_ready), .rom_data(rom_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] instr;
      logic        vld;
      logic        stop;
      logic        err;
      logic        req;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: one outstanding fetch, one held entry
   bit          m_busy = 0;
   bit          m_have = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_data = '0;
   bit          m_err  = 0;
   int          m_waits = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endfunction

   function automatic void model_reset();
      m_busy = 0;
      m_have = 0;
   endfunction

   // Advance the model by one clock using the inputs held during the past cycle
   function automatic void model_update();
      logic [31:0] w;
      bit          hit;
      w   = program_counter & 32'hFFFF_FFFC;
      hit = m_have && (m_addr == w);
      if (!reset) return;
      if (!chip_enable || flush_input) begin
         m_busy = 0;
         m_have = 0;
      end else if (m_busy) begin
         if (rom_ready) begin
            m_busy = 0; m_have = 1; m_data = rom_data; m_err = 0; m_addr = m_pend;
         end else begin
            m_waits++;
            if (m_waits >= T) begin
               m_busy = 0; m_have = 1; m_data = '0; m_err = 1; m_addr = m_pend;
            end
         end
      end else if (!hit) begin
         m_pend  = w;
         m_waits = 0;
         m_have  = 0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (program_counter[1:0] != 2'b00) begin
            m_have = 1; m_data = '0; m_err = 1; m_addr = w;
         end else m_busy = 1;
`else
         m_busy = 1;
`endif
      end
   endfunction

   task automatic step(input logic r, input logic ce, input logic [31:0] pc,
                       input logic fl, input logic rdy, input logic [31:0] d);
      exp_t e;
      bit   hit;
      @(posedge clock);
      model_update();
      #1;
      reset = r; chip_enable = ce; program_counter = pc;
      flush_input = fl; rom_ready = rdy; rom_data = d;
      if (!r) model_reset();
      hit     = m_have && (m_addr == (pc & 32'hFFFF_FFFC));
      e.stop  = r && ce && !hit;
      e.vld   = ce && hit;
      e.instr = e.vld ? m_data : 32'h0;
      e.err   = e.vld && m_err;
      e.req   = m_busy;
      e.addr  = m_busy ? m_pend : 32'h0;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the DUT against the oldest prediction mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instruction",       instruction,              e.instr);
            chk("instruction_valid", 32'(instruction_valid),   32'(e.vld));
            chk("stop_request",      32'(stop_request),        32'(e.stop));
            chk("fetch_error",       32'(fetch_error),         32'(e.err));
            chk("rom_request",       32'(rom_request),         32'(e.req));
            chk("rom_address",       rom_address,              e.addr);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pool [6];
      logic [31:0] pc;
      int          dead;
      pool[0] = 32'h0;   pool[1] = 32'h4;   pool[2] = 32'h8;
      pool[3] = 32'h100; pool[4] = 32'h104; pool[5] = 32'h6;

      // Reset state
      repeat (2) step(0, 1, 32'h0, 0, 0, 32'h0);

      // Zero-wait fetch
      repeat (4) step(1, 1, 32'h0, 0, 1, 32'h3C01_0001);

      // Wait states: ready on the third WAIT cycle
      step(1, 1, 32'h100, 0, 0, 32'h1111_1111);
      step(1, 1, 32'h100, 0, 0, 32'h2222_2222);
      step(1, 1, 32'h100, 0, 0, 32'h3333_3333);
      step(1, 1, 32'h100, 0, 1, 32'h4444_4444);
      repeat (3) step(1, 1, 32'h100, 0, 0, 32'h0);

      // Timeout
      repeat (22) step(1, 1, 32'h200, 0, 0, 32'h5555_5555);

      // Flush colliding with rom_ready
      step(1, 1, 32'h300, 0, 0, 32'h0);
      step(1, 1, 32'h300, 1, 1, 32'hDEAD_BEEF);
      step(1, 1, 32'h300, 0, 0, 32'h0);
      step(1, 1, 32'h300, 0, 1, 32'h0000_0300);
      repeat (2) step(1, 1, 32'h300, 0, 0, 32'h0);

      // Disable mid-fetch
      step(1, 1, 32'h500, 0, 0, 32'h0);
      step(1, 0, 32'h500, 0, 0, 32'h0);
      step(1, 0, 32'h500, 0, 1, 32'h0);

      // Asynchronous reset mid-WAIT
      step(1, 1, 32'h400, 0, 0, 32'h0);
      step(1, 1, 32'h400, 0, 0, 32'h0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_rst rom_request",  32'(rom_request),  32'h0);
      chk("async_rst stop_request", 32'(stop_request), 32'h0);
      chk("async_rst rom_address",  rom_address,       32'h0);
      step(0, 1, 32'h4, 0, 0, 32'h0);
      step(1, 1, 32'h4, 0, 0, 32'h0);
      step(1, 1, 32'h4, 0, 1, 32'hCAFE_0004);
      repeat (2) step(1, 1, 32'h4, 0, 0, 32'h0);

      // Misaligned PC
      repeat (4) step(1, 1, 32'h6, 0, 1, 32'h0BAD_0006);

      // Randomized traffic
      pc   = 32'h0;
      dead = 0;
      for (int i = 0; i < 3000; i++) begin
         logic r, ce, fl, rdy;
         if ($urandom_range(99) < 25) pc = pool[$urandom_range(5)];
         if (dead == 0 && $urandom_range(99) < 3) dead = 20;
         r   = ($urandom_range(99) >= 1);
         ce  = ($urandom_range(99) >= 5);
         fl  = ($urandom_range(99) < 4);
         rdy = (dead == 0) && ($urandom_range(1) == 1);
         if (dead > 0) dead--;
         step(r, ce, pc, fl, rdy, $urandom);
      end

      step(1, 0, 32'h0, 0, 0, 32'h0);
      @(negedge clock);
      #1;
      chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
